// File: rtl/skynet_udiv_pkg.sv
// skynet_udiv_pkg: shared types and default widths for the
// sequential unsigned divider (FSM state, operand widths).
package skynet_udiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIVIDEND_W = 19;
   localparam int DIVISOR_W  = 8;

endpackage

// File: rtl/skynet_udiv_step.sv
// skynet_udiv_step: one combinational restoring-division iteration.
// Ports: rem_in/bit_in/divisor in; rem_out (new partial rem), q_bit out.
module skynet_udiv_step #(
   parameter int DIVISOR_WIDTH = 8
) (
   input  logic [DIVISOR_WIDTH:0]   rem_in,
   input  logic                     bit_in,
   input  logic [DIVISOR_WIDTH-1:0] divisor,
   output logic [DIVISOR_WIDTH:0]   rem_out,
   output logic                     q_bit
);

   logic [DIVISOR_WIDTH+1:0] shifted;
   logic [DIVISOR_WIDTH+1:0] diff;

   // One extra bit on the trial difference: its MSB is the borrow,
   // so a clear MSB means the subtraction was non-negative.
   always_comb begin
      shifted = {rem_in, bit_in};
      diff    = shifted - {2'b00, divisor};
      q_bit   = ~diff[DIVISOR_WIDTH+1];
      rem_out = q_bit ? diff[DIVISOR_WIDTH:0]
                      : shifted[DIVISOR_WIDTH:0];
   end

endmodule

// File: rtl/skynet_udiv_seq.sv
// skynet_udiv_seq: sequential radix-2 restoring unsigned divider.
// Ports: ap_clk, ap_rst_n; in_valid/in_ready + dividend/divisor in;
// out_valid/out_ready + quotient/remainder/div_by_zero out.
module skynet_udiv_seq
   import skynet_udiv_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_W,
   parameter int DIVISOR_WIDTH  = DIVISOR_W
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIVIDEND_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero
);

   localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DIVIDEND_WIDTH - 1);

   state_t                    state_q;
   state_t                    state_d;
   logic [DIVIDEND_WIDTH-1:0] dvd_q;
   logic [DIVISOR_WIDTH-1:0]  dvs_q;
   logic [DIVISOR_WIDTH:0]    rem_q;
   logic [DIVISOR_WIDTH:0]    rem_d;
   logic [CW-1:0]             cnt_q;
   logic                      dbz_q;
   logic                      q_bit;

   skynet_udiv_step #(
      .DIVISOR_WIDTH(DIVISOR_WIDTH)
   ) u_step (
      .rem_in (rem_q),
      .bit_in (dvd_q[DIVIDEND_WIDTH-1]),
      .divisor(dvs_q),
      .rem_out(rem_d),
      .q_bit  (q_bit)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // A zero divisor still spends one cycle in BUSY, where the
   // saturated result is loaded instead of iterating.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = BUSY;
         BUSY:    if (dbz_q || cnt_q == LAST) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // The dividend register shifts out numerator bits MSB first and
   // shifts in quotient bits at the LSB, ending as the quotient.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  dvd_q <= dividend;
                  dvs_q <= divisor;
                  rem_q <= '0;
                  cnt_q <= '0;
                  dbz_q <= (divisor == '0);
               end
            end
            BUSY: begin
               if (dbz_q) begin
                  dvd_q <= '1;
                  rem_q <= '0;
               end else begin
                  dvd_q <= {dvd_q[DIVIDEND_WIDTH-2:0], q_bit};
                  rem_q <= rem_d;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient    = dvd_q;
   assign remainder   = rem_q[DIVISOR_WIDTH-1:0];
   assign div_by_zero = dbz_q;

endmodule
